tb_phase_ctrl: RTL and testbench

Synthesizable-style test-phase sequencer for the bench top. Drives the DUT reset, tracks run time with a cycle-accurate watchdog, accepts a test-done handshake, drains for a fixed time and then signals finish. It replaces ad-hoc initial-block reset and timeout delays with one clocked controller that tests can observe and kick.

---
 rtl/tb_phase_pkg.sv | 40 ++++
 rtl/tb_phase_cnt.sv | 45 ++++
 rtl/tb_phase_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_tb_phase_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_phase_pkg.sv
//------------------------------------------------------------------------------
// Module   : tb_phase_pkg
// Brief    : Shared phase encoding, default parameter set and phase helpers
//            for the bench-top phase sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package tb_phase_pkg;

  // Encoded controller phase; the value is exported on the phase port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4,
    TOUT  = 3'd5
  } phase_e;

  // Default parameter set used by the controller when not overridden.
  localparam int c_def_rst_cycles   = 50;
  localparam int c_def_wdog_cycles  = 1000000;
  localparam int c_def_drain_cycles = 16;
  localparam int c_def_cnt_w        = 32;

  // Phases in which abort takes effect.
  function automatic logic phase_abortable(input phase_e p);
    return (p == RESET) || (p == RUN) || (p == DRAIN);
  endfunction

  // Phases in which the DUT is released from reset.
  function automatic logic phase_dut_released(input phase_e p);
    return (p == RUN) || (p == DRAIN) || (p == DONE) || (p == TOUT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tb_phase_cnt.sv
//------------------------------------------------------------------------------
// Module   : tb_phase_cnt
// Brief    : CNT_W-bit counter with synchronous clear, load and increment,
//            plus an equality compare against a terminal-count value.
//            Priority: clr > load > inc.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_phase_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic [CNT_W-1:0] tc_val,
  output logic [CNT_W-1:0] count,
  output logic             at_tc
);

  logic [CNT_W-1:0] r_count;

  // Counter register: clear wins over load, load wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;
  assign at_tc = (r_count == tc_val);

endmodule

`default_nettype wire

// File: rtl/tb_phase_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_phase_ctrl
// Brief    : Bench-top test-phase sequencer. Holds the DUT in reset for
//            RST_CYCLES, runs a watchdog during RUN, accepts a test_done
//            handshake, drains for DRAIN_CYCLES and then pulses finish.
//            Optional macro TB_PHASE_KICK_EN enables watchdog reload via kick.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_phase_ctrl
  import tb_phase_pkg::*;
#(
  parameter int RST_CYCLES   = c_def_rst_cycles,
  parameter int WDOG_CYCLES  = c_def_wdog_cycles,
  parameter int DRAIN_CYCLES = c_def_drain_cycles,
  parameter int CNT_W        = c_def_cnt_w
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             test_done,
  output logic             done_ack,
  input  logic             kick,
  input  logic             abort,
  output logic             dut_rst_n,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             timeout,
  output logic             finish
);

  // Largest value a CNT_W counter can hold (CNT_W limited to < 63).
  localparam longint c_cnt_max = (longint'(1) << CNT_W) - 1;

  // Elaboration-time parameter sanity checks.
  if (CNT_W < 2 || CNT_W > 62) begin : g_bad_cnt_w
    $error("tb_phase_ctrl: CNT_W must be in 2..62");
  end
  if (RST_CYCLES < 1 || longint'(RST_CYCLES) > c_cnt_max) begin : g_bad_rst_cycles
    $error("tb_phase_ctrl: RST_CYCLES must be in 1..2^CNT_W-1");
  end
  if (WDOG_CYCLES < 1 || longint'(WDOG_CYCLES) > c_cnt_max) begin : g_bad_wdog_cycles
    $error("tb_phase_ctrl: WDOG_CYCLES must be in 1..2^CNT_W-1");
  end
  if (DRAIN_CYCLES < 0 || longint'(DRAIN_CYCLES) > c_cnt_max) begin : g_bad_drain_cycles
    $error("tb_phase_ctrl: DRAIN_CYCLES must be in 0..2^CNT_W-1");
  end

  // Terminal counts: a phase ends on the cycle its counter equals N-1.
  localparam logic [CNT_W-1:0] c_rst_tc   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_wdog_tc  = CNT_W'(WDOG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_drain_tc = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] c_all_ones = {CNT_W{1'b1}};

  phase_e           r_state;
  phase_e           w_state_nxt;
  logic             r_dut_rst_n;
  logic             r_done_ack;
  logic             r_finish;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cycle_cnt;

  logic             w_dut_rst_n_nxt;
  logic             w_done_ack_nxt;
  logic             w_finish_nxt;
  logic             w_timeout_nxt;
  logic [CNT_W-1:0] w_cycle_cnt_nxt;

  logic             w_abort_hit;
  logic             w_kick_hit;

  logic             w_ph_load;
  logic             w_ph_inc;
  logic [CNT_W-1:0] w_ph_tc;
  logic             w_ph_at_tc;
  logic [CNT_W-1:0] w_ph_cnt_unused;

  logic             w_wd_clr;
  logic             w_wd_inc;
  logic             w_wd_at_tc;
  logic [CNT_W-1:0] w_wd_cnt_unused;

  assign w_abort_hit = abort && phase_abortable(r_state);

`ifdef TB_PHASE_KICK_EN
  assign w_kick_hit = kick && (r_state == RUN);
`else
  logic w_kick_unused;
  assign w_kick_unused = kick;
  assign w_kick_hit    = 1'b0;
`endif

  // Phase counter: restarts from 0 on every phase change and on abort,
  // counts only while in RESET or DRAIN.
  assign w_ph_load = (w_state_nxt != r_state);
  assign w_ph_inc  = (r_state == RESET) || (r_state == DRAIN);
  assign w_ph_tc   = (r_state == RESET) ? c_rst_tc : c_drain_tc;

  tb_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_abort_hit),
    .load     (w_ph_load),
    .load_val ('0),
    .inc      (w_ph_inc),
    .tc_val   (w_ph_tc),
    .count    (w_ph_cnt_unused),
    .at_tc    (w_ph_at_tc)
  );

  // Watchdog: held at 0 outside RUN so it starts from 0 on RUN entry;
  // a kick (when enabled) reloads it to 0.
  assign w_wd_clr = (r_state != RUN) || w_kick_hit;
  assign w_wd_inc = (r_state == RUN);

  tb_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_wdog_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_wd_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (w_wd_inc),
    .tc_val   (c_wdog_tc),
    .count    (w_wd_cnt_unused),
    .at_tc    (w_wd_at_tc)
  );

  // Next-state and next-output decode; abort beats test_done beats expiry.
  always_comb begin
    w_state_nxt    = r_state;
    w_done_ack_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RESET;
      end
      RESET: begin
        if (abort)           w_state_nxt = RESET;
        else if (w_ph_at_tc) w_state_nxt = RUN;
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = RESET;
        end else if (test_done) begin
          w_done_ack_nxt = 1'b1;
          if (DRAIN_CYCLES == 0) w_state_nxt = DONE;
          else                   w_state_nxt = DRAIN;
        end else if (w_wd_at_tc && !w_kick_hit) begin
          w_state_nxt = TOUT;
        end
      end
      DRAIN: begin
        if (abort)           w_state_nxt = RESET;
        else if (w_ph_at_tc) w_state_nxt = DONE;
      end
      DONE, TOUT: begin
        w_state_nxt = r_state;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_dut_rst_n_nxt = phase_dut_released(w_state_nxt);
    w_finish_nxt    = (w_state_nxt != r_state) &&
                      ((w_state_nxt == DONE) || (w_state_nxt == TOUT));
    w_timeout_nxt   = r_timeout || (w_state_nxt == TOUT);

    w_cycle_cnt_nxt = r_cycle_cnt;
    if (w_abort_hit) begin
      w_cycle_cnt_nxt = '0;
    end else if ((r_state == RUN) && (r_cycle_cnt != c_all_ones)) begin
      w_cycle_cnt_nxt = r_cycle_cnt + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dut_rst_n <= 1'b0;
      r_done_ack  <= 1'b0;
      r_finish    <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dut_rst_n <= w_dut_rst_n_nxt;
      r_done_ack  <= w_done_ack_nxt;
      r_finish    <= w_finish_nxt;
      r_timeout   <= w_timeout_nxt;
      r_cycle_cnt <= w_cycle_cnt_nxt;
    end
  end

  assign phase     = r_state;
  assign dut_rst_n = r_dut_rst_n;
  assign done_ack  = r_done_ack;
  assign finish    = r_finish;
  assign timeout   = r_timeout;
  assign cycle_cnt = r_cycle_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tb_phase_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_tb_phase_ctrl
// Brief    : Directed self-checking bench for tb_phase_ctrl. Instance A uses
//            50/1000/16 cycles, instance B uses 2/100/0 with an 8-bit counter.
//            Kick expectations follow the TB_PHASE_KICK_EN macro.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_tb_phase_ctrl;
  import tb_phase_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a = 1'b0, test_done_a = 1'b0, kick_a = 1'b0, abort_a = 1'b0;
  logic        done_ack_a, dut_rst_n_a, timeout_a, finish_a;
  logic [2:0]  phase_a;
  logic [31:0] cycle_cnt_a;

  logic        start_b = 1'b0, test_done_b = 1'b0, kick_b = 1'b0, abort_b = 1'b0;
  logic        done_ack_b, dut_rst_n_b, timeout_b, finish_b;
  logic [2:0]  phase_b;
  logic [7:0]  cycle_cnt_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tb_phase_ctrl #(
    .RST_CYCLES (50), .WDOG_CYCLES (1000), .DRAIN_CYCLES (16), .CNT_W (32)
  ) u_dut_a (
    .clk (clk), .rst (rst), .start (start_a), .test_done (test_done_a),
    .done_ack (done_ack_a), .kick (kick_a), .abort (abort_a),
    .dut_rst_n (dut_rst_n_a), .phase (phase_a), .cycle_cnt (cycle_cnt_a),
    .timeout (timeout_a), .finish (finish_a)
  );

  tb_phase_ctrl #(
    .RST_CYCLES (2), .WDOG_CYCLES (100), .DRAIN_CYCLES (0), .CNT_W (8)
  ) u_dut_b (
    .clk (clk), .rst (rst), .start (start_b), .test_done (test_done_b),
    .done_ack (done_ack_b), .kick (kick_b), .abort (abort_b),
    .dut_rst_n (dut_rst_n_b), .phase (phase_b), .cycle_cnt (cycle_cnt_b),
    .timeout (timeout_b), .finish (finish_b)
  );

  // Compare one observed value against its expected value.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges and settle 1ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Count consecutive observations of phase ph on A (bounded); also counts
  // observations where dut_rst_n was high.
  task automatic count_phase_a(input logic [2:0] ph, input int limit,
                               output int n, output int hi);
    n  = 0;
    hi = 0;
    while (phase_a == ph && n < limit) begin
      if (dut_rst_n_a !== 1'b0) hi++;
      n++;
      tick(1);
    end
  endtask

  task automatic count_phase_b(input logic [2:0] ph, input int limit, output int n);
    n = 0;
    while (phase_b == ph && n < limit) begin
      n++;
      tick(1);
    end
  endtask

  // Stimulus and checks.
  initial begin
    int n;
    int hi;
    int tout_at;

    // Reset state; start asserted during rst must be ignored.
    rst     = 1'b1;
    start_a = 1'b1;
    tick(2);
    check_val("rst_phase_a",  32'(phase_a), 32'(IDLE));
    check_val("rst_dutrst_a", 32'(dut_rst_n_a), 32'd0);
    check_val("rst_cyc_a",    cycle_cnt_a, 32'd0);
    check_val("rst_tout_a",   32'(timeout_a), 32'd0);
    check_val("rst_fin_a",    32'(finish_a), 32'd0);
    check_val("rst_ack_a",    32'(done_ack_a), 32'd0);
    check_val("rst_phase_b",  32'(phase_b), 32'(IDLE));
    start_a = 1'b0;
    rst     = 1'b0;

    tick(3);
    check_val("idle_phase_a", 32'(phase_a), 32'(IDLE));
    check_val("idle_dutrst_a", 32'(dut_rst_n_a), 32'd0);

    // Bring-up: 50 cycles of RESET, RUN coincides with dut_rst_n rising.
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    count_phase_a(3'(RESET), 500, n, hi);
    check_val("reset_len_a", n, 50);
    check_val("reset_low_a", hi, 0);
    check_val("run_phase_a", 32'(phase_a), 32'(RUN));
    check_val("run_dutrst_a", 32'(dut_rst_n_a), 32'd1);
    check_val("run_cyc0_a", cycle_cnt_a, 32'd0);

    // test_done during the 200th RUN cycle.
    tick(199);
    check_val("pre_done_cyc_a", cycle_cnt_a, 32'd199);
    test_done_a = 1'b1;
    tick(1);
    test_done_a = 1'b0;
    check_val("drain_phase_a", 32'(phase_a), 32'(DRAIN));
    check_val("done_ack_a", 32'(done_ack_a), 32'd1);
    check_val("drain_cyc_a", cycle_cnt_a, 32'd200);
    tick(1);
    check_val("done_ack_off_a", 32'(done_ack_a), 32'd0);
    check_val("drain_frozen_a", cycle_cnt_a, 32'd200);
    tick(14);
    check_val("drain15_phase_a", 32'(phase_a), 32'(DRAIN));
    check_val("drain15_fin_a", 32'(finish_a), 32'd0);
    tick(1);
    check_val("done_phase_a", 32'(phase_a), 32'(DONE));
    check_val("done_fin_a", 32'(finish_a), 32'd1);
    tick(1);
    check_val("done_fin_off_a", 32'(finish_a), 32'd0);
    start_a = 1'b1;
    abort_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    abort_a = 1'b0;
    check_val("done_hold_a", 32'(phase_a), 32'(DONE));
    check_val("done_dutrst_a", 32'(dut_rst_n_a), 32'd1);

    // Abort at RUN cycle 50 replays the full reset.
    pulse_rst();
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    count_phase_a(3'(RESET), 500, n, hi);
    check_val("reset_len2_a", n, 50);
    tick(50);
    check_val("pre_abort_cyc_a", cycle_cnt_a, 32'd50);
    abort_a = 1'b1;
    tick(1);
    abort_a = 1'b0;
    check_val("abort_phase_a", 32'(phase_a), 32'(RESET));
    check_val("abort_dutrst_a", 32'(dut_rst_n_a), 32'd0);
    check_val("abort_cyc_a", cycle_cnt_a, 32'd0);
    count_phase_a(3'(RESET), 500, n, hi);
    check_val("replay_len_a", n, 50);
    check_val("replay_low_a", hi, 0);
    check_val("replay_run_a", 32'(phase_a), 32'(RUN));

    // Watchdog expiry after 1000 RUN cycles.
    count_phase_a(3'(RUN), 1500, n, hi);
    check_val("run_len_a", n, 1000);
    check_val("tout_phase_a", 32'(phase_a), 32'(TOUT));
    check_val("tout_flag_a", 32'(timeout_a), 32'd1);
    check_val("tout_fin_a", 32'(finish_a), 32'd1);
    check_val("tout_cyc_a", cycle_cnt_a, 32'd1000);
    check_val("tout_dutrst_a", 32'(dut_rst_n_a), 32'd1);
    tick(1);
    check_val("tout_fin_off_a", 32'(finish_a), 32'd0);
    test_done_a = 1'b1;
    abort_a     = 1'b1;
    tick(1);
    test_done_a = 1'b0;
    abort_a     = 1'b0;
    check_val("tout_hold_a", 32'(phase_a), 32'(TOUT));
    check_val("tout_noack_a", 32'(done_ack_a), 32'd0);
    check_val("tout_sticky_a", 32'(timeout_a), 32'd1);

    // Instance B: test_done on the watchdog expiry cycle, zero drain.
    pulse_rst();
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    count_phase_b(3'(RESET), 50, n);
    check_val("reset_len_b", n, 2);
    tick(99);
    check_val("exp_phase_b", 32'(phase_b), 32'(RUN));
    check_val("exp_cyc_b", 32'(cycle_cnt_b), 32'd99);
    test_done_b = 1'b1;
    tick(1);
    test_done_b = 1'b0;
    check_val("exp_done_b", 32'(phase_b), 32'(DONE));
    check_val("exp_ack_b", 32'(done_ack_b), 32'd1);
    check_val("exp_fin_b", 32'(finish_b), 32'd1);
    check_val("exp_tout_b", 32'(timeout_b), 32'd0);
    check_val("exp_cyc2_b", 32'(cycle_cnt_b), 32'd100);

    // Instance B: kick every 80 RUN cycles for 500 cycles.
    pulse_rst();
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    count_phase_b(3'(RESET), 50, n);
    tout_at = 0;
    for (int i = 0; i < 500; i++) begin
      kick_b = ((i % 80) == 79);
      tick(1);
      kick_b = 1'b0;
      if (tout_at == 0 && phase_b == 3'(TOUT)) tout_at = i + 1;
    end
`ifdef TB_PHASE_KICK_EN
    check_val("kick_tout_at_b", tout_at, 0);
    check_val("kick_phase_b", 32'(phase_b), 32'(RUN));
    check_val("kick_flag_b", 32'(timeout_b), 32'd0);
    check_val("kick_sat_b", 32'(cycle_cnt_b), 32'd255);
`else
    check_val("nokick_tout_at_b", tout_at, 100);
    check_val("nokick_phase_b", 32'(phase_b), 32'(TOUT));
    check_val("nokick_flag_b", 32'(timeout_b), 32'd1);
    check_val("nokick_cyc_b", 32'(cycle_cnt_b), 32'd100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #1000000;
    $display("FAIL global_timeout: got %0d vectors expected completion", n_vec);
    $fatal(1, "bench time limit reached");
  end

endmodule

`default_nettype wire
